fetch_unit: RTL and testbench

Program-counter and sequencing stage that sits directly upstream of the instruction decoder. It drives the address into the combinational instruction ROM and advances, branches or halts based on the decoder's branch-enable and done (Ack) outputs plus the ALU branch condition. It also provides the host-side Start/Done handshake and a run-cycle counter for benchmarking.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Program-counter and sequencing stage in front of the instruction decoder.
// ProgCtr_o addresses a combinational instruction ROM; the decoder and ALU
// return Ack/BranchEn/BranchTaken/Target for that address in the same cycle,
// and this block picks the next PC: halt, branch, or step by one.
//
// Ports
//   Clk_i          system clock, rising edge
//   Reset_i        asynchronous active-high reset
//   Start_i        host run request (level, sampled on the rising edge)
//   Ack_i          decoder done flag for the current instruction
//   BranchEn_i     decoder branch-on-equal flag for the current instruction
//   BranchTaken_i  ALU branch condition for the current instruction
//   Target_i       absolute branch target (PC_W bits)
//   ProgCtr_o      registered ROM address
//   Running_o      registered, high while in RUN
//   Done_o         registered, high while in HALT
//   CycleCnt_o     registered count of RUN cycles in the current/last run
//   State_o        registered FSM state, for observation only
//
// Host handshake: the host raises Start_i and holds it until it sees
// Running_o; it must then drop Start_i, because Start_i is a level and a
// high Start_i in HALT restarts the program on the next edge. Start_i is
// ignored while running. Done_o stays high until the next Start_i or reset.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter int              CNT_W      = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Start_i,
    input  logic             Ack_i,
    input  logic             BranchEn_i,
    input  logic             BranchTaken_i,
    input  logic [PC_W-1:0]  Target_i,
    output logic [PC_W-1:0]  ProgCtr_o,
    output logic             Running_o,
    output logic             Done_o,
    output logic [CNT_W-1:0] CycleCnt_o,
    output logic [1:0]       State_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q,   state_d;
    logic [PC_W-1:0]  pc_q,      pc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             running_q, running_d;
    logic             done_q,    done_d;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start_i) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // Every RUN cycle executes one instruction, including the
                // final Ack instruction, so the count always advances.
                cnt_d = cnt_inc;
                if (Ack_i) begin
                    // Ack has priority over a simultaneous taken branch; the
                    // PC stays on the Ack instruction.
                    state_d = S_HALT;
                end else if (BranchEn_i && BranchTaken_i) begin
                    pc_d = Target_i;
                end else begin
                    // Natural PC_W-bit overflow wraps the last address to 0.
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                // Unused encoding recovers to IDLE.
                state_d = S_IDLE;
            end
        endcase
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_HALT);
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ProgCtr_o  = pc_q;
    assign Running_o  = running_q;
    assign Done_o     = done_q;
    assign CycleCnt_o = cnt_q;
    assign State_o    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 1: default widths ----------------
    logic        start;
    logic        ack, br_en, br_taken;
    logic [9:0]  target;
    logic [9:0]  prog_ctr;
    logic        running, done;
    logic [15:0] cycle_cnt;
    logic [1:0]  state;

    // ROM + decoder model, combinational on the PC
    logic       rom_ack [0:1023];
    logic       rom_be  [0:1023];
    logic       rom_bt  [0:1023];
    logic [9:0] rom_tgt [0:1023];

    assign ack      = rom_ack[prog_ctr];
    assign br_en    = rom_be[prog_ctr];
    assign br_taken = rom_bt[prog_ctr];
    assign target   = rom_tgt[prog_ctr];

    fetch_unit #(.PC_W(10), .CNT_W(16), .START_ADDR(10'd0)) dut (
        .Clk_i(clk), .Reset_i(rst), .Start_i(start),
        .Ack_i(ack), .BranchEn_i(br_en), .BranchTaken_i(br_taken),
        .Target_i(target), .ProgCtr_o(prog_ctr), .Running_o(running),
        .Done_o(done), .CycleCnt_o(cycle_cnt), .State_o(state)
    );

    // ---------------- DUT 2: narrow widths for wrap / saturation ----------------
    logic       start2;
    logic       zero1;
    logic [3:0] target2;
    logic [3:0] prog_ctr2;
    logic       running2, done2;
    logic [3:0] cycle_cnt2;
    logic [1:0] state2;

    fetch_unit #(.PC_W(4), .CNT_W(4), .START_ADDR(4'd0)) dut2 (
        .Clk_i(clk), .Reset_i(rst), .Start_i(start2),
        .Ack_i(zero1), .BranchEn_i(zero1), .BranchTaken_i(zero1),
        .Target_i(target2), .ProgCtr_o(prog_ctr2), .Running_o(running2),
        .Done_o(done2), .CycleCnt_o(cycle_cnt2), .State_o(state2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) begin
            rom_ack[i] = 1'b0;
            rom_be[i]  = 1'b0;
            rom_bt[i]  = 1'b0;
            rom_tgt[i] = 10'd0;
        end
    endtask

    // Walk the program as the architecture defines it and queue the PCs
    // that should be presented, one per RUN cycle.
    task automatic build_exp(output int n);
        int pc;
        pc = 0;
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            exp_q.push_back(32'(pc));
            if (rom_ack[pc]) break;
            else if (rom_be[pc] && rom_bt[pc]) pc = int'(rom_tgt[pc]);
            else pc = (pc + 1) % 1024;
        end
        n = exp_q.size();
    endtask

    // Start the program, compare PC every RUN cycle, finish on HALT.
    // start_at: RUN-cycle index at which Start is raised again (-1: never).
    task automatic run_prog(input string name, input int start_at);
        int n_exp;
        int cyc;
        logic [31:0] e;
        build_exp(n_exp);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_start_run"},  32'(running),   32'd1);
        chk({name, "_start_done"}, 32'(done),      32'd0);
        chk({name, "_start_cnt"},  32'(cycle_cnt), 32'd0);
        cyc = 0;
        while (running && cyc < 300) begin
            if (exp_q.size() == 0) begin
                chk({name, "_extra_pc"}, 32'(prog_ctr), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk({name, "_pc"}, 32'(prog_ctr), e);
            end
            start = (cyc == start_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({name, "_bound"},    32'(cyc < 300),    32'd1);
        chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_done"},     32'(done),         32'd1);
        chk({name, "_cnt"},      32'(cycle_cnt),    32'(n_exp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a;
        start   = 1'b0;
        start2  = 1'b0;
        zero1   = 1'b0;
        target2 = 4'd0;
        clear_rom();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",      32'(prog_ctr),  32'd0);
        chk("rst_running", 32'(running),   32'd0);
        chk("rst_done",    32'(done),      32'd0);
        chk("rst_cnt",     32'(cycle_cnt), 32'd0);
        chk("rst_state",   32'(state),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold_pc",  32'(prog_ctr), 32'd0);
        chk("idle_hold_run", 32'(running),  32'd0);

        // 4 NOPs then Ack at address 4
        clear_rom();
        rom_ack[4] = 1'b1;
        run_prog("nop4", -1);
        chk("nop4_cnt5", 32'(cycle_cnt), 32'd5);
        chk("nop4_pc4",  32'(prog_ctr),  32'd4);
        @(posedge clk); #1;
        chk("nop4_halt_hold_pc",   32'(prog_ctr),  32'd4);
        chk("nop4_halt_hold_done", 32'(done),      32'd1);
        chk("nop4_halt_hold_cnt",  32'(cycle_cnt), 32'd5);

        // Taken branch at 2 -> 7, Ack at 8 (restart from HALT)
        clear_rom();
        rom_be[2] = 1'b1; rom_bt[2] = 1'b1; rom_tgt[2] = 10'd7;
        rom_ack[8] = 1'b1;
        run_prog("br_taken", -1);
        chk("br_taken_pc8", 32'(prog_ctr), 32'd8);

        // Untaken branch at 2, Ack at 3; Start raised mid-run is ignored
        clear_rom();
        rom_be[2] = 1'b1; rom_bt[2] = 1'b0; rom_tgt[2] = 10'd7;
        rom_ack[3] = 1'b1;
        run_prog("br_not", 1);
        chk("br_not_pc3", 32'(prog_ctr), 32'd3);

        // Ack and taken branch together at 3: Ack wins
        clear_rom();
        rom_ack[3] = 1'b1;
        rom_be[3] = 1'b1; rom_bt[3] = 1'b1; rom_tgt[3] = 10'd9;
        run_prog("ack_br", -1);
        chk("ack_br_pc3", 32'(prog_ctr),  32'd3);
        chk("ack_br_cnt", 32'(cycle_cnt), 32'd4);

        // Random forward-branching programs
        for (int r = 0; r < 4; r++) begin
            clear_rom();
            a = $urandom_range(20, 60);
            rom_ack[a] = 1'b1;
            for (int b = 0; b < 6; b++) begin
                int at;
                at = $urandom_range(0, a);
                rom_be[at]  = 1'b1;
                rom_bt[at]  = 1'($urandom_range(0, 1));
                rom_tgt[at] = 10'($urandom_range(at + 1, a));
            end
            run_prog("rand", int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a run at PC 5
        clear_rom();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_pc5", 32'(prog_ctr), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_pc",      32'(prog_ctr),  32'd0);
        chk("arst_running", 32'(running),   32'd0);
        chk("arst_cnt",     32'(cycle_cnt), 32'd0);
        chk("arst_done",    32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle_pc",  32'(prog_ctr), 32'd0);
        chk("arst_idle_run", 32'(running),  32'd0);

        // Narrow instance: PC wraps 15 -> 0, counter saturates at 15
        exp_q.delete();
        for (int k = 0; k <= 20; k++) exp_q.push_back(32'(k % 16));
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("w4_pc",  32'(prog_ctr2),  e);
            chk("w4_cnt", 32'(cycle_cnt2), 32'((k < 15) ? k : 15));
            chk("w4_run", 32'(running2),   32'd1);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
